// File: rtl/gppcu_issue_arbiter.sv
// Round-robin arbiter sharing the GPPCU instruction-queue push port between NUM_REQ sources.
// A grant is held for a whole kernel (first beat through last), optionally draining until GPPCU done.
module gppcu_issue_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DBW        = 32,
  parameter int DONE_GUARD = 2
) (
  input  logic                   iACLK,
  input  logic                   inRST,
  input  logic [NUM_REQ-1:0]     iREQ_VALID,
  input  logic [NUM_REQ-1:0]     iREQ_LAST,
  input  logic [NUM_REQ*DBW-1:0] iREQ_DATA,
  output logic [NUM_REQ-1:0]     oREQ_READY,
  input  logic                   iSYNC_EN,
  input  logic                   iQ_FULL,
  input  logic                   iQ_DONE,
  output logic                   oQ_PUSH,
  output logic [DBW-1:0]         oQ_DATA,
  output logic [NUM_REQ-1:0]     oGRANT,
  output logic                   oBUSY,
  output logic [15:0]            oKERNEL_CNT
);

  localparam int unsigned NR = NUM_REQ;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (DONE_GUARD > 0) ? $clog2(DONE_GUARD + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       owner, owner_nxt;
  logic [IW-1:0]       rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]       winner;
  logic                any_valid;
  logic [GW-1:0]       guard, guard_nxt, guard_inc;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic [15:0]         kcnt_nxt;
  logic                fire;
  logic                fire_last;

  // First valid requester scanning upward from the slot after the previous owner.
  always_comb begin : pick_winner
    int unsigned idx;
    idx       = 0;
    winner    = rr_ptr;
    any_valid = 1'b0;
    for (int unsigned i = 1; i <= NR; i++) begin
      idx = (32'(rr_ptr) + i) % NR;
      if (!any_valid && iREQ_VALID[IW'(idx)]) begin
        winner    = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    oREQ_READY = '0;
    oQ_DATA    = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (owner == IW'(k)) begin
        oREQ_READY[k] = (state == XFER) && !iQ_FULL;
        oQ_DATA       = iREQ_DATA[k*DBW +: DBW];
      end
    end
  end

  assign fire      = |(oREQ_READY & iREQ_VALID);
  assign fire_last = |(oREQ_READY & iREQ_VALID & iREQ_LAST);
  assign oQ_PUSH   = fire;
  assign oBUSY     = (state != IDLE);
  assign guard_inc = (guard == GW'(DONE_GUARD)) ? guard : guard + 1'b1;

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = oGRANT;
    guard_nxt  = guard;
    kcnt_nxt   = oKERNEL_CNT;
    case (state)
      IDLE: begin
        if (any_valid) begin
          owner_nxt         = winner;
          grant_nxt         = '0;
          grant_nxt[winner] = 1'b1;
          state_nxt         = XFER;
        end
      end
      XFER: begin
        if (fire_last) begin
          kcnt_nxt   = oKERNEL_CNT + 16'd1;
          rr_ptr_nxt = owner;
          if (iSYNC_EN) begin
            state_nxt = DRAIN;
            guard_nxt = '0;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end
      end
      DRAIN: begin
        // Exit is judged on the incremented count, so DRAIN lasts exactly DONE_GUARD cycles when done is already high.
        guard_nxt = guard_inc;
        if ((guard_inc == GW'(DONE_GUARD)) && iQ_DONE) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= IW'(NUM_REQ - 1);
      oGRANT      <= '0;
      guard       <= '0;
      oKERNEL_CNT <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      oGRANT      <= grant_nxt;
      guard       <= guard_nxt;
      oKERNEL_CNT <= kcnt_nxt;
    end
  end

endmodule

// File: tb/tb_gppcu_issue_arbiter.sv
// Self-checking bench for gppcu_issue_arbiter: per-requester beat queues drive the DUT,
// and a transaction-level owner/round-robin model predicts every output each cycle.
module tb_gppcu_issue_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int DG = 2;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   valid, last, ready, grant;
  logic [N*W-1:0] data;
  logic           sync_en, q_full, q_done, q_push, busy;
  logic [W-1:0]   q_data;
  logic [15:0]    kcnt;

  always #5 clk = ~clk;

  gppcu_issue_arbiter #(.NUM_REQ(N), .DBW(W), .DONE_GUARD(DG)) dut (
    .iACLK(clk), .inRST(rst_n),
    .iREQ_VALID(valid), .iREQ_LAST(last), .iREQ_DATA(data), .oREQ_READY(ready),
    .iSYNC_EN(sync_en), .iQ_FULL(q_full), .iQ_DONE(q_done),
    .oQ_PUSH(q_push), .oQ_DATA(q_data), .oGRANT(grant), .oBUSY(busy), .oKERNEL_CNT(kcnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: who owns the port, whether it is draining, and the last finished owner.
  int          m_owner, m_dcnt, m_last;
  bit          m_drain;
  logic [15:0] m_kcnt;
  beat_t       src_q[N][$];
  int          gap_pct;
  logic [N-1:0] s_grant, s_ready, prev_grant;
  logic         s_push, s_busy;
  logic [W-1:0] s_data;
  logic [N-1:0] glog[$];

  task automatic model_reset();
    m_owner = -1; m_drain = 0; m_dcnt = 0; m_last = N - 1; m_kcnt = '0;
    for (int k = 0; k < N; k++) src_q[k].delete();
  endtask

  task automatic enq(input int k, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.last = l; b.data = d;
    src_q[k].push_back(b);
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0 && !(gap_pct > 0 && $urandom_range(99) < gap_pct)) begin
        valid[k] = 1'b1; last[k] = src_q[k][0].last; data[k*W +: W] = src_q[k][0].data;
      end else begin
        valid[k] = 1'b0; last[k] = 1'($urandom_range(1)); data[k*W +: W] = $urandom;
      end
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg, er;
    logic ep;
    eg = '0; er = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (m_owner >= 0 && !m_drain && !q_full) er[m_owner] = 1'b1;
    ep = |(er & valid);
    check_eq("grant", 32'(grant), 32'(eg));
    check_eq("ready", 32'(ready), 32'(er));
    check_eq("push", 32'(q_push), 32'(ep));
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    check_eq("kernel_cnt", 32'(kcnt), 32'(m_kcnt));
    if (ep) check_eq("push_data", q_data, src_q[m_owner][0].data);
    check_eq("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    if (q_push) check_eq("push_one_ready", 32'($onehot(ready)), 32'd1);
  endtask

  task automatic model_step();
    beat_t b;
    if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        int j;
        j = (m_last + i) % N;
        if (valid[j]) begin m_owner = j; break; end
      end
    end else if (!m_drain) begin
      if (!q_full && valid[m_owner]) begin
        b = src_q[m_owner].pop_front();
        if (b.last) begin
          m_kcnt++;
          m_last = m_owner;
          if (sync_en) begin m_drain = 1; m_dcnt = 0; end
          else m_owner = -1;
        end
      end
    end else begin
      m_dcnt++;
      if (m_dcnt >= DG && q_done) begin m_drain = 0; m_owner = -1; end
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    s_grant = grant; s_ready = ready; s_push = q_push; s_busy = busy; s_data = q_data;
    compare_model();
    if (grant != prev_grant && grant != '0) glog.push_back(grant);
    prev_grant = grant;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_grant"}, 32'(grant), 32'd0);
    check_eq({tag, "_ready"}, 32'(ready), 32'd0);
    check_eq({tag, "_push"}, 32'(q_push), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_kcnt"}, 32'(kcnt), 32'd0);
  endtask

  // Called at posedge+1; reset is asserted and released well away from both edges.
  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 reset_checks(tag);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, guard_cycles, pending;
    logic [31:0] exp_ord[4];
    rst_n = 1'b0; valid = '0; last = '0; data = '0;
    sync_en = 0; q_full = 0; q_done = 0; gap_pct = 0; prev_grant = '0;
    model_reset();
    #12 reset_checks("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: three-beat kernel from requester 1
    enq(1, 32'hA0, 0); enq(1, 32'hA1, 0); enq(1, 32'hA2, 1);
    tick(); check_eq("t1_idle_grant", 32'(s_grant), 32'd0);
    tick(); check_eq("t1_grant", 32'(s_grant), 32'b0010);
    check_eq("t1_beat0", s_data, 32'hA0);
    tick(); check_eq("t1_beat1", s_data, 32'hA1); check_eq("t1_push1", 32'(s_push), 32'd1);
    tick(); check_eq("t1_beat2", s_data, 32'hA2); check_eq("t1_push2", 32'(s_push), 32'd1);
    tick(); check_eq("t1_idle_after", 32'(s_busy), 32'd0); check_eq("t1_kcnt", 32'(kcnt), 32'd1);

    // 2: contenders 0,2,3 with single-beat kernels, from a fresh pointer
    do_reset("t2_rst");
    enq(0, 32'hB0, 1); enq(0, 32'hB1, 1); enq(2, 32'hB2, 1); enq(3, 32'hB3, 1);
    glog.delete(); prev_grant = '0;
    repeat (10) tick();
    exp_ord = '{32'b0001, 32'b0100, 32'b1000, 32'b0001};
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t2_order%0d", i), (i < glog.size()) ? 32'(glog[i]) : 32'hDEAD, exp_ord[i]);

    // 3: backpressure mid-kernel on requester 0 while requester 2 waits
    enq(0, 32'hC0, 0); enq(0, 32'hC1, 0); enq(0, 32'hC2, 1);
    tick(); tick();
    check_eq("t3_first_push", 32'(s_push), 32'd1);
    enq(2, 32'hC9, 1);
    q_full = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t3_full_ready", 32'(s_ready), 32'd0);
      check_eq("t3_full_push", 32'(s_push), 32'd0);
      check_eq("t3_full_grant", 32'(s_grant), 32'b0001);
    end
    q_full = 0;
    tick(); check_eq("t3_resume_push", 32'(s_push), 32'd1); check_eq("t3_resume_data", s_data, 32'hC1);
    repeat (5) tick();

    // 4: sync mode, done already high, then done held low
    sync_en = 1; q_done = 1;
    enq(1, 32'hD0, 1);
    tick(); tick();
    check_eq("t4_last_push", 32'(s_push), 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!s_busy) break;
      n++;
    end
    check_eq("t4_drain_cycles", 32'(n), 32'(DG));
    q_done = 0;
    enq(1, 32'hD1, 1);
    tick(); tick();
    enq(3, 32'hD3, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t4_hold_grant", 32'(s_grant), 32'b0010);
    end
    q_done = 1;
    tick(); tick(); check_eq("t4_released", 32'(s_grant), 32'd0);
    tick(); check_eq("t4_next_grant", 32'(s_grant), 32'b1000);
    tick(); tick(); tick();
    sync_en = 0;

    // 5: async reset during requester 2 transfer, then tie 0 vs 2
    enq(2, 32'hE0, 0); enq(2, 32'hE1, 0); enq(2, 32'hE2, 1);
    repeat (3) tick();
    do_reset("t5_rst");
    enq(0, 32'hF0, 1); enq(2, 32'hF2, 1);
    tick(); tick();
    check_eq("t5_tie_grant", 32'(s_grant), 32'b0001);
    repeat (5) tick();

    // Randomized traffic against the model
    gap_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      q_full  = ($urandom_range(3) == 0);
      q_done  = 1'($urandom_range(1));
      sync_en = 1'($urandom_range(1));
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() == 0 && $urandom_range(3) == 0) begin
          n = $urandom_range(4, 1);
          for (int b = 0; b < n; b++) enq(k, $urandom, 1'(b == n - 1));
        end
      end
      tick();
    end
    gap_pct = 0; q_full = 0; q_done = 1; sync_en = 0;
    pending = 1;
    for (int c = 0; c < 300 && pending != 0; c++) begin
      tick();
      pending = (m_owner >= 0) ? 1 : 0;
      for (int k = 0; k < N; k++) if (src_q[k].size() > 0) pending = 1;
    end
    check_eq("rand_drain_done", 32'(pending), 32'd0);

    // 6: run the kernel counter up to 0xFFFF, then wrap
    guard_cycles = 0;
    while (m_kcnt != 16'hFFFF && guard_cycles < 140000) begin
      if (src_q[0].size() == 0) enq(0, $urandom, 1);
      tick();
      guard_cycles++;
    end
    check_eq("t6_preload", 32'(kcnt), 32'hFFFF);
    guard_cycles = 0;
    while (m_kcnt != 16'h0000 && guard_cycles < 10) begin
      if (src_q[0].size() == 0) enq(0, $urandom, 1);
      tick();
      guard_cycles++;
    end
    check_eq("t6_wrap", 32'(kcnt), 32'h0000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gppcu_issue_arbiter.md
Name: gppcu_issue_arbiter

Overview:
- Shares the GPPCU instruction-queue push port between NUM_REQ instruction sources, such as the host bridge, the boot loader and the DMA kernel loader.
- Grants one requester at a time using round-robin arbitration.
- Holds the grant for a whole kernel, from the first beat through the beat flagged last, so instructions from different sources never interleave.
- Respects the queue-full backpressure and can optionally wait for GPPCU completion between kernels.
- Sits between the requesters and the queue write side of the GPPCU test/queue wrapper, in the iACLK domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DBW, 32, instruction word width.
- DONE_GUARD, 2, minimum cycles spent in DRAIN before iQ_DONE is sampled (covers done-flag latency after the last push).

Ports:
- iACLK  in  1  clock; all state changes on its rising edge.
- inRST  in  1  asynchronous, active-low reset.
- iREQ_VALID  in  NUM_REQ  per-requester instruction valid.
- iREQ_LAST  in  NUM_REQ  per-requester marker for the last instruction of a kernel.
- iREQ_DATA  in  NUM_REQ*DBW  packed instruction words; requester k occupies [k*DBW +: DBW].
- oREQ_READY  out  NUM_REQ  per-requester ready.
- iSYNC_EN  in  1  when 1, wait for GPPCU done after each kernel before re-arbitrating.
- iQ_FULL  in  1  instruction-queue full flag.
- iQ_DONE  in  1  queue empty and GPPCU idle.
- oQ_PUSH  out  1  queue write strobe.
- oQ_DATA  out  DBW  queue write data.
- oGRANT  out  NUM_REQ  one-hot current owner; 0 when no owner.
- oBUSY  out  1  high in any state other than IDLE.
- oKERNEL_CNT  out  16  count of completed kernels (beats accepted with last); wraps at 16 bits.

Behaviour:
- Reset: the async assert forces, in the same instant:
  - state=IDLE, oGRANT=0, oBUSY=0, oKERNEL_CNT=0;
  - rr_ptr = NUM_REQ-1, so requester 0 wins first;
  - guard counter = 0.
  oREQ_READY and oQ_PUSH are 0 while in reset. A reset mid-kernel drops the kernel; no completion of a partial transfer is guaranteed.
- FSM states: IDLE, XFER, DRAIN.
- IDLE:
  - oREQ_READY=0 and oQ_PUSH=0.
  - If any iREQ_VALID is 1, the winner is the first valid index scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - On the next edge: oGRANT <= onehot(winner), state <= XFER. Grant latency is 1 cycle from valid.
- XFER, with g the granted index:
  - oREQ_READY[g] = ~iQ_FULL (combinational); all other ready bits are 0.
  - fire = iREQ_VALID[g] & oREQ_READY[g].
  - oQ_PUSH = fire and oQ_DATA = iREQ_DATA[g], both combinational, so one instruction per cycle is possible.
  - While iQ_FULL=1: no fire, and the grant is held indefinitely.
  - Valid dropping mid-kernel leaves the grant held; there is no timeout.
  - Requests from other sources are ignored until the grant is released.
- On fire with iREQ_LAST[g]=1:
  - oKERNEL_CNT <= oKERNEL_CNT+1 (wraps 0xFFFF→0) and rr_ptr <= g.
  - If iSYNC_EN=1: state <= DRAIN, guard <= 0, and oGRANT stays set.
  - Else: oGRANT <= 0, state <= IDLE.
  - The next grant is therefore at least 2 cycles after the last beat.
- DRAIN:
  - No readies and no push.
  - guard increments, saturating at DONE_GUARD.
  - When guard==DONE_GUARD and iQ_DONE=1: oGRANT <= 0, state <= IDLE.
  - iQ_DONE is ignored before the guard expires, which avoids a stale done flag.
- iSYNC_EN is sampled only on the last-beat fire.
- Single requester: the same requester may be regranted immediately in IDLE; the round-robin pointer only orders contenders.
- oBUSY = (state != IDLE), registered with the state.
- oGRANT is always one-hot or 0. The bench asserts this, and asserts that oQ_PUSH implies exactly one ready bit is high.

Test Plan:
1. Reset, then requester 1 sends 3 beats (0xA0,0xA1,0xA2 with last on the 3rd), iQ_FULL=0, iSYNC_EN=0.
   - oGRANT=0b0010 one cycle after valid.
   - oQ_PUSH on 3 consecutive cycles with data A0,A1,A2.
   - oKERNEL_CNT=1, then IDLE.
2. Requesters 0, 2 and 3 all valid, each sending single-beat kernels.
   - Grant order 0, 2, 3, then 0 again.
   - No interleaving of requesters within a kernel.
3. Requester 0 mid-kernel with iQ_FULL forced to 1 for 5 cycles; requester 2 valid throughout.
   - oREQ_READY=0 and no oQ_PUSH for 5 cycles.
   - Grant stays 0b0001.
   - Transfer resumes on the cycle iQ_FULL drops.
4. iSYNC_EN=1, last beat pushed, iQ_DONE already 1.
   - Stays in DRAIN for exactly DONE_GUARD=2 cycles, then IDLE.
   - With iQ_DONE held 0 for 20 cycles: no new grant until it rises.
5. inRST pulsed low during XFER of requester 2.
   - oGRANT=0, oREQ_READY=0, oQ_PUSH=0 and oKERNEL_CNT=0 immediately, asynchronously.
   - After release, requester 0 wins a tie with requester 2.
6. Preload oKERNEL_CNT to 0xFFFF by running 65535 single-beat kernels.
   - One more kernel → oKERNEL_CNT=0x0000.
